vmem_arbiter: RTL
=================

// Module: vmem_arbiter
// PURPOSE
//  Shares the single-port 24-bit frame buffer between VGA scan-out and a pixel writer
//  (console/keyboard path). Scan-out reads always win and are never stalled.
//  Writer requests are queued in a FIFO and committed to memory only during blanking.
//  Sits between vga_ctrl (h_addr/v_addr/valid) and the frame-buffer RAM.
// PARAMETERS
//  FIFO_DEPTH  16  write-queue entries; power of 2, >= 2
//  AW          19  memory address width = {h_addr[9:0], v_addr[8:0]}
//  DW          24  pixel width, RGB888
// PORTS
//  clk         in   1      pixel clock; same clock as vga_ctrl
//  resetn      in   1      asynchronous, active-low reset
//  vga_valid   in   1      from vga_ctrl; 1 = active video, 0 = blanking
//  h_addr      in   10     scan-out column
//  v_addr      in   9      scan-out row
//  vga_data    out  DW     pixel to vga_ctrl
//  wr_valid    in   1      writer request
//  wr_ready    out  1      queue can accept a request
//  wr_addr     in   AW     target address {col,row}
//  wr_data     in   DW     pixel value
//  mem_addr    out  AW     RAM address; RAM read is combinational
//  mem_we      out  1      RAM write enable; write is sampled on rising clk
//  mem_wdata   out  DW     RAM write data
//  mem_rdata   in   DW     RAM read data
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  current queue occupancy
// BEHAVIOUR
//  Reset values: state=SCAN, FIFO empty, fifo_level=0, wr_ready=1, mem_we=0.
//   All pending writes are dropped, including on a mid-frame reset.
//  Write handshake:
//   - A request is accepted on a rising clk when wr_valid && wr_ready.
//   - wr_ready = !full. It depends only on registered state, never on wr_valid.
//   - A push while full is ignored, even if a pop occurs in the same cycle.
//   - Push and pop in the same cycle: level is unchanged, order is preserved (FIFO).
//  FSM, registered:
//   - SCAN: entered or held whenever vga_valid=1.
//   - SCAN -> GUARD when vga_valid=0. GUARD lasts exactly 1 cycle with no write.
//   - GUARD -> DRAIN if vga_valid is still 0; otherwise -> SCAN.
//   - DRAIN -> SCAN on vga_valid=1.
//  Datapath:
//   - mem_we = (state==DRAIN) && !vga_valid && !empty. This is gated combinationally,
//     so no write is ever issued in a cycle with vga_valid=1.
//   - mem_we=1: mem_addr = FIFO head addr, mem_wdata = head data; pop on that edge.
//   - Otherwise: mem_addr = {h_addr, v_addr}, mem_wdata = 0.
//   - vga_data = vga_valid ? mem_rdata : 0. Read latency is 0 cycles (combinational).
//  Throughput and boundaries:
//   - At most 1 write per cycle. The first write of each blanking interval occurs on
//     its 2nd cycle.
//   - A blanking interval of 1 cycle yields no writes.
//   - FIFO empty in DRAIN: mem_we=0, state stays DRAIN.
//   - FIFO pointers wrap modulo FIFO_DEPTH; level saturates neither way.
//   - A write whose address equals the scanned address is committed only in blanking.
//     The new pixel appears from the next frame or line that scans it.
// TESTING
//  1. Reset with wr_valid=1 held -> wr_ready=1, fifo_level=0, mem_we=0 for the whole
//     reset; no push until resetn rises.
//  2. vga_valid=1, push 3 writes (A=0x00005/0xFF0000, B, C) -> fifo_level=3, mem_we
//     never 1; vga_data tracks mem_rdata of {h_addr,v_addr}.
//  3. Then vga_valid->0 for 5 cycles -> cycle 1 no write; cycles 2-4 write A,B,C in
//     order; cycle 5 mem_we=0; fifo_level=0.
//  4. Fill FIFO_DEPTH=16 during active -> wr_ready=0 at level 16; a 17th wr_valid is
//     not accepted; after 1 drain write, wr_ready=1.
//  5. vga_valid rises mid-drain with 4 entries after 2 writes -> mem_we=0 that same
//     cycle, level=2, remaining 2 drained in the next blanking.
//  6. resetn pulsed low in DRAIN with level=5 -> level=0, state=SCAN, no further writes.

Source files
------------

// File: rtl/vmem_arbiter.sv
// -----------------------------------------------------------------------------
// vmem_arbiter
//
// Purpose
//   Shares one single-port RGB888 frame buffer between VGA scan-out and a
//   pixel writer (console / keyboard path). Scan-out reads always win and are
//   never stalled. Writer requests wait in a FIFO and are committed to memory
//   only during blanking. The first blanking cycle is a guard cycle with no
//   write, so a blanking interval of one cycle commits nothing.
//
// Ports
//   clk         in   pixel clock (shared with vga_ctrl)
//   resetn      in   asynchronous active-low reset; drops all queued writes
//   vga_valid   in   1 = active video, 0 = blanking
//   h_addr      in   scan-out column
//   v_addr      in   scan-out row
//   vga_data    out  pixel to vga_ctrl (0 during blanking)
//   wr_valid    in   writer request
//   wr_ready    out  queue can accept a request (= !full, registered state only)
//   wr_addr     in   target address {col,row}
//   wr_data     in   pixel value
//   mem_addr    out  RAM address (combinational read)
//   mem_we      out  RAM write enable, sampled on rising clk
//   mem_wdata   out  RAM write data
//   mem_rdata   in   RAM read data
//   fifo_level  out  current queue occupancy
// -----------------------------------------------------------------------------
module vmem_arbiter #(
  parameter int FIFO_DEPTH = 16,
  parameter int AW         = 19,
  parameter int DW         = 24
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          vga_valid,
  input  logic [9:0]                    h_addr,
  input  logic [8:0]                    v_addr,
  output logic [DW-1:0]                 vga_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [DW-1:0]                 wr_data,
  output logic [AW-1:0]                 mem_addr,
  output logic                          mem_we,
  output logic [DW-1:0]                 mem_wdata,
  input  logic [DW-1:0]                 mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    GUARD = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // FSM
  // state_q holds the state of the previous cycle. The state in force this
  // cycle is decoded from it and the live vga_valid, so the guard cycle lines
  // up with the very first blanking cycle and a rising vga_valid takes the
  // arbiter back to SCAN in the same cycle (no write can collide with video).
  // ---------------------------------------------------------------------------
  state_e state_q;
  state_e state_d;
  state_e cur_state;

  always_comb begin
    cur_state = SCAN;
    if (!vga_valid) begin
      case (state_q)
        SCAN:    cur_state = GUARD;
        GUARD:   cur_state = DRAIN;
        DRAIN:   cur_state = DRAIN;
        default: cur_state = GUARD;
      endcase
    end
    state_d = cur_state;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= SCAN;
    end else begin
      // NOTE: sequential state is always updated with non-blocking assignments
      // so every flop samples values from before the edge.
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Write queue
  // ---------------------------------------------------------------------------
  logic [AW-1:0] addr_mem [FIFO_DEPTH];
  logic [DW-1:0] data_mem [FIFO_DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (level_q == LW'(FIFO_DEPTH));
  assign empty = (level_q == '0);

  // A push while full is refused even if a pop happens on the same edge,
  // because wr_ready is derived from registered occupancy only.
  assign wr_ready   = !full;
  assign push       = wr_valid && wr_ready;
  assign fifo_level = level_q;

  // Redundant vga_valid term keeps the no-write-during-video guarantee local
  // to this line, independent of the state decode above.
  assign mem_we = (cur_state == DRAIN) && !vga_valid && !empty;
  assign pop    = mem_we;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    // Pointers are PW bits wide, so they wrap modulo FIFO_DEPTH on their own.
    if (push) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and level
  // define which entries are valid, and leaving RAM-like storage out of reset
  // lets it map onto memory primitives.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wptr_q] <= wr_addr;
      data_mem[wptr_q] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory port mux and scan-out data
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_addr  = AW'({h_addr, v_addr});
    mem_wdata = '0;
    if (mem_we) begin
      mem_addr  = addr_mem[rptr_q];
      mem_wdata = data_mem[rptr_q];
    end
  end

  // Read latency is zero: the RAM read is combinational on mem_addr.
  assign vga_data = vga_valid ? mem_rdata : '0;

endmodule
